spi_clk_gen: RTL and testbench

- Serial-clock generator that sits directly upstream of spi_shift.
- Divides wb_clk down to produce sclk.
- Issues the one-cycle edge strobes cpol_0 (leading edge) and cpol_1 (trailing edge) that step spi_shift.
- Adds a programmable setup delay before the first edge and a guard interval after the final edge, then reports completion to the control/register stage.

---
 rtl/spi_clk_gen_if.sv | 26 ++
 rtl/spi_clk_gen.sv | 131 +++++++++++++
 tb/tb_spi_clk_gen.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_clk_gen_if.sv
// Handshake bundle between spi_clk_gen and its control/shift neighbours.
// master drives the control inputs; slave is the clock generator.
interface spi_clk_gen_if #(
  parameter int DIVIDER_LEN = 16
);
  logic                   go;
  logic                   enable;
  logic                   last_clk;
  logic [DIVIDER_LEN-1:0] divider;
  logic                   cpol;
  logic                   sclk;
  logic                   cpol_0;
  logic                   cpol_1;
  logic                   busy;
  logic                   done;

  modport master (
    output go, enable, last_clk, divider, cpol,
    input  sclk, cpol_0, cpol_1, busy, done
  );

  modport slave (
    input  go, enable, last_clk, divider, cpol,
    output sclk, cpol_0, cpol_1, busy, done
  );
endinterface

// File: rtl/spi_clk_gen.sv
// SPI serial clock generator: divides wb_clk into sclk, issues edge
// strobes for spi_shift, adds setup delay and guard hold around a transfer.
module spi_clk_gen #(
  parameter int DIVIDER_LEN = 16
) (
  input logic          wb_clk,
  input logic          wb_reset_n,
  spi_clk_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    RUN,
    HOLD
  } state_t;

  state_t                 state;
  state_t                 state_n;
  logic [DIVIDER_LEN-1:0] cnt;
  logic [DIVIDER_LEN-1:0] cnt_n;
  logic [DIVIDER_LEN-1:0] div_r;
  logic [DIVIDER_LEN-1:0] div_n;
  logic                   cpol_r;
  logic                   cpol_n;
  logic                   lvl;
  logic                   lvl_n;
  logic                   sclk;
  logic                   sclk_n;
  logic                   c0;
  logic                   c0_n;
  logic                   c1;
  logic                   c1_n;
  logic                   done;
  logic                   done_n;
  logic                   busy;
  logic                   tick;

  assign tick = (cnt == '0);

  // lvl is the level sclk will take on the cycle after a strobe;
  // edge decisions use it so divider=0 can strobe every cycle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    div_n   = div_r;
    cpol_n  = cpol_r;
    lvl_n   = lvl;
    sclk_n  = lvl;
    c0_n    = 1'b0;
    c1_n    = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        sclk_n = bus.cpol;
        lvl_n  = bus.cpol;
        cnt_n  = bus.divider;
        if (bus.go) begin
          div_n   = bus.divider;
          cpol_n  = bus.cpol;
          state_n = SETUP;
        end
      end
      SETUP, RUN: begin
        if (!bus.enable) begin
          state_n = IDLE;
          sclk_n  = cpol_r;
          lvl_n   = cpol_r;
        end else if (!tick) begin
          cnt_n = cnt - DIVIDER_LEN'(1);
        end else begin
          cnt_n   = div_r;
          state_n = RUN;
          if (lvl != cpol_r) begin
            c1_n  = 1'b1;
            lvl_n = cpol_r;
          end else if (!bus.last_clk) begin
            c0_n  = 1'b1;
            lvl_n = ~cpol_r;
          end else begin
            c0_n    = 1'b1;
            state_n = HOLD;
          end
        end
      end
      HOLD: begin
        if (!tick) begin
          cnt_n = cnt - DIVIDER_LEN'(1);
        end else begin
          cnt_n   = div_r;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_reset_n) begin
    if (!wb_reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      div_r  <= '0;
      cpol_r <= 1'b0;
      lvl    <= 1'b0;
      sclk   <= 1'b0;
      c0     <= 1'b0;
      c1     <= 1'b0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      div_r  <= div_n;
      cpol_r <= cpol_n;
      lvl    <= lvl_n;
      sclk   <= sclk_n;
      c0     <= c0_n;
      c1     <= c1_n;
      done   <= done_n;
      busy   <= (state != IDLE);
    end
  end

  assign bus.sclk   = sclk;
  assign bus.cpol_0 = c0;
  assign bus.cpol_1 = c1;
  assign bus.busy   = busy;
  assign bus.done   = done;

endmodule

// File: tb/tb_spi_clk_gen.sv
// Directed bench for spi_clk_gen; cycle k is sampled 1ns after the k-th
// rising edge counted from the edge that samples go.
module tb_spi_clk_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  spi_clk_gen_if #(.DIVIDER_LEN(16)) bus ();

  spi_clk_gen #(.DIVIDER_LEN(16)) dut (
    .wb_clk    (clk),
    .wb_reset_n(rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [15:0] div, input logic cp);
    bus.divider = div;
    bus.cpol    = cp;
    bus.go      = 1'b1;
    step();
    bus.go = 1'b0;
  endtask

  task automatic abort_out();
    bus.enable = 1'b0;
    step();
    bus.enable = 1'b1;
    step();
    step();
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    #12;
    obs = {bus.sclk, bus.cpol_0, bus.cpol_1, bus.busy, bus.done};
    total++;
    if (obs !== 5'b0) begin
      bad++;
      $display("FAIL reset_outs got=%b exp=00000", obs);
    end
    #10 rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [3:0] exp [0:7];
    logic [3:0] obs;
    exp = '{4'b0000, 4'b1000, 4'b1100, 4'b1001,
            4'b1011, 4'b1000, 4'b1100, 4'b1001};
    start(16'd1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      obs = {bus.busy, bus.cpol_0, bus.cpol_1, bus.sclk};
      total++;
      if (obs !== exp[k]) begin
        bad++;
        $display("FAIL basic_c%0d got=%b exp=%b", k, obs, exp[k]);
      end
    end
    abort_out();
  endtask

  task automatic test_div0();
    int   n0 = 0;
    int   hi = 0;
    logic prev = 1'b0;
    start(16'd0, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      step();
      if (bus.cpol_0) n0++;
      if (bus.sclk && !prev) hi++;
      prev = bus.sclk;
      total++;
      if ((bus.cpol_0 & bus.cpol_1) !== 1'b0) begin
        bad++;
        $display("FAIL div0_excl_c%0d got=1 exp=0", k);
      end
    end
    total++;
    if (n0 != 8 || hi != 8) begin
      bad++;
      $display("FAIL div0_counts got=%0d/%0d exp=8/8", n0, hi);
    end
    bus.last_clk = 1'b1;
    step();
    total++;
    if ({bus.cpol_0, bus.sclk, bus.busy} !== 3'b101) begin
      bad++;
      $display("FAIL div0_term got=%b exp=101",
               {bus.cpol_0, bus.sclk, bus.busy});
    end
    bus.last_clk = 1'b0;
    step();
    total++;
    if ({bus.done, bus.busy, bus.cpol_0, bus.sclk} !== 4'b1100) begin
      bad++;
      $display("FAIL div0_done got=%b exp=1100",
               {bus.done, bus.busy, bus.cpol_0, bus.sclk});
    end
    step();
    total++;
    if ({bus.done, bus.busy} !== 2'b00) begin
      bad++;
      $display("FAIL div0_idle got=%b exp=00", {bus.done, bus.busy});
    end
  endtask

  task automatic test_cpol1();
    logic got;
    logic exp;
    bus.cpol = 1'b1;
    step();
    step();
    total++;
    if (bus.sclk !== 1'b1) begin
      bad++;
      $display("FAIL cpol1_idle got=%b exp=1", bus.sclk);
    end
    start(16'd3, 1'b1);
    for (int k = 1; k <= 17; k++) begin
      step();
      if (k == 10) bus.last_clk = 1'b1;
      got = 1'bx;
      exp = 1'bx;
      case (k)
        4:  begin got = bus.cpol_0; exp = 1'b1; end
        5:  begin got = bus.sclk;   exp = 1'b0; end
        8:  begin got = bus.cpol_1; exp = 1'b1; end
        9:  begin got = bus.sclk;   exp = 1'b1; end
        12: begin got = bus.cpol_0; exp = 1'b1; end
        13: begin got = bus.sclk;   exp = 1'b1; end
        15: begin got = bus.done;   exp = 1'b0; end
        16: begin got = bus.done;   exp = 1'b1; end
        17: begin got = bus.busy;   exp = 1'b0; end
        default: ;
      endcase
      if (exp !== 1'bx) begin
        total++;
        if (got !== exp) begin
          bad++;
          $display("FAIL cpol1_c%0d got=%b exp=%b", k, got, exp);
        end
      end
    end
    bus.last_clk = 1'b0;
  endtask

  task automatic test_abort();
    int extra = 0;
    start(16'd2, 1'b0);
    repeat (4) step();
    total++;
    if (bus.sclk !== 1'b1) begin
      bad++;
      $display("FAIL abort_pre got=%b exp=1", bus.sclk);
    end
    bus.enable = 1'b0;
    step();
    bus.enable = 1'b1;
    total++;
    if ({bus.sclk, bus.cpol_1, bus.done} !== 3'b000) begin
      bad++;
      $display("FAIL abort_next got=%b exp=000",
               {bus.sclk, bus.cpol_1, bus.done});
    end
    step();
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_busy got=%b exp=0", bus.busy);
    end
    for (int k = 0; k < 4; k++) begin
      if (bus.cpol_1 || bus.done) extra++;
      step();
    end
    total++;
    if (extra != 0) begin
      bad++;
      $display("FAIL abort_quiet got=%0d exp=0", extra);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] obs;
    logic [1:0] exp;
    start(16'd2, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 1) begin
        bus.divider = 16'd7;
        bus.go      = 1'b1;
      end
      if (k == 2) bus.go = 1'b0;
      exp = {(k == 3 || k == 9), (k == 6 || k == 12)};
      obs = {bus.cpol_0, bus.cpol_1};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL hold_div_c%0d got=%b exp=%b", k, obs, exp);
      end
    end
    abort_out();
    start(16'd7, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 7 || k == 8 || k == 16) begin
        exp = {(k == 8), (k == 16)};
        obs = {bus.cpol_0, bus.cpol_1};
        total++;
        if (obs !== exp) begin
          bad++;
          $display("FAIL next_div_c%0d got=%b exp=%b", k, obs, exp);
        end
      end
    end
    abort_out();
  endtask

  task automatic test_reset_mid();
    int stray = 0;
    start(16'd5, 1'b1);
    repeat (6) step();
    total++;
    if ({bus.cpol_0, bus.sclk, bus.busy} !== 3'b111) begin
      bad++;
      $display("FAIL rst_pre got=%b exp=111",
               {bus.cpol_0, bus.sclk, bus.busy});
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.sclk, bus.cpol_0, bus.cpol_1, bus.busy, bus.done} !== 5'b0) begin
      bad++;
      $display("FAIL rst_async got=%b exp=00000",
               {bus.sclk, bus.cpol_0, bus.cpol_1, bus.busy, bus.done});
    end
    #10 rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (bus.busy || bus.cpol_0 || bus.cpol_1 || bus.done) stray++;
    end
    total++;
    if (stray != 0) begin
      bad++;
      $display("FAIL rst_idle got=%0d exp=0", stray);
    end
  endtask

  initial begin
    bus.go       = 1'b0;
    bus.enable   = 1'b1;
    bus.last_clk = 1'b0;
    bus.divider  = 16'd0;
    bus.cpol     = 1'b0;
    test_reset();
    test_basic();
    test_div0();
    test_cpol1();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
